controlador_ascensor: RTL and testbench

Per-car motion/door sequencer for the two-car elevator system. It latches floor calls, runs a SCAN (collective) schedule, and times travel between floors and door dwell. It drives the same piso / direccion / puertas_abiertas bundle that the display and LED controllers consume. One instance per car replaces the fixed test-pattern generators.

---
 rtl/asc_pkg.sv | 27 ++
 rtl/temporizador_asc.sv | 30 +++
 rtl/controlador_ascensor.sv | 185 ++++++++++++++++++
 tb/tb_controlador_ascensor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/asc_pkg.sv
// Shared definitions for the elevator car controller.
// Holds the direction codes, the FSM encoding and the floor-index width helper.
// Pure declarations, no logic and no flow control.
package asc_pkg;

    // Direction codes driven on 'direccion'. 2'b11 is never produced.
    localparam logic [1:0] DIR_PARADO = 2'b00;
    localparam logic [1:0] DIR_SUBE   = 2'b01;
    localparam logic [1:0] DIR_BAJA   = 2'b10;

    // Car sequencer states.
    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        MOVIENDO = 2'd1,
        PUERTAS  = 2'd2
    } estado_t;

    // Width of a floor index for a building of n floors (at least one bit).
    function automatic int ancho_piso(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Floor-index width for the default four-floor building.
    localparam int N_PISOS_DEF = 4;
    localparam int PISO_W      = ancho_piso(N_PISOS_DEF);

endpackage

// File: rtl/temporizador_asc.sv
// Loadable down-counter shared by travel and door timing.
// Load takes effect on the next edge; expira is high while enabled and the count is zero.
// No flow control: habilitar gates counting, a load always wins over counting.
module temporizador_asc #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cargar,
    input  logic [ANCHO-1:0] valor_carga,
    input  logic             habilitar,
    output logic             expira
);

    logic [ANCHO-1:0] cuenta;

    // Count register: load has priority, otherwise count down and hold at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cuenta <= '0;
        end else if (cargar) begin
            cuenta <= valor_carga;
        end else if (habilitar && (cuenta != '0)) begin
            cuenta <= cuenta - 1'b1;
        end
    end

    assign expira = habilitar && (cuenta == '0);

endmodule

// File: rtl/controlador_ascensor.sv
// Per-car SCAN sequencer: latches floor calls, times travel per floor and door dwell.
// All outputs registered; a call is acted on at the same edge that samples it.
// No backpressure; optional ASC_PARADA_EMERGENCIA_EN adds 'parada', which freezes motion and timers.
module controlador_ascensor
    import asc_pkg::*;
#(
    parameter int N_PISOS       = 4,
    parameter int TIEMPO_PISO   = 50_000_000,
    parameter int TIEMPO_PUERTA = 100_000_000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_PISOS-1:0]                llamadas,
`ifdef ASC_PARADA_EMERGENCIA_EN
    input  logic                              parada,
`endif
    output logic [ancho_piso(N_PISOS)-1:0]    piso,
    output logic [1:0]                        direccion,
    output logic                              puertas_abiertas,
    output logic [N_PISOS-1:0]                pendientes,
    output logic                              ocupado
);

    localparam int PW    = ancho_piso(N_PISOS);
    localparam int T_MAX = (TIEMPO_PISO > TIEMPO_PUERTA) ? TIEMPO_PISO : TIEMPO_PUERTA;
    localparam int TW    = $clog2(T_MAX);

    // Timer reload values: counting N-1 down to 0 and expiring on the following
    // edge gives exactly N cycles per floor / per door dwell.
    localparam logic [TW-1:0] CARGA_PISO   = TW'(TIEMPO_PISO - 1);
    localparam logic [TW-1:0] CARGA_PUERTA = TW'(TIEMPO_PUERTA - 1);

    estado_t           estado, estado_sig;
    logic [PW-1:0]     piso_sig, piso_adelante;
    logic [1:0]        dir_sig;
    logic [N_PISOS-1:0] pend_nxt, pend_sig;
    logic              hay_arriba, hay_abajo;
    logic              congelado;
    logic              cargar, habilitar, expira;
    logic [TW-1:0]     valor_carga;

`ifdef ASC_PARADA_EMERGENCIA_EN
    assign congelado = parada;
`else
    assign congelado = 1'b0;
`endif

    // New calls merge into the pending set before any decision is taken.
    assign pend_nxt = pendientes | llamadas;

    // The floor the car reaches when the current travel leg completes.
    assign piso_adelante = (direccion == DIR_BAJA) ? (piso - PW'(1)) : (piso + PW'(1));

    // The timer only runs while the car is travelling or the doors are open.
    assign habilitar = !congelado && (estado != REPOSO);

    // Classify pending calls relative to the current floor.
    always_comb begin
        hay_arriba = 1'b0;
        hay_abajo  = 1'b0;
        for (int i = 0; i < N_PISOS; i++) begin
            if (pend_nxt[i] && (i > int'(piso))) hay_arriba = 1'b1;
            if (pend_nxt[i] && (i < int'(piso))) hay_abajo  = 1'b1;
        end
    end

    // Next-state, floor, direction, pending set and timer control.
    always_comb begin
        estado_sig  = estado;
        piso_sig    = piso;
        dir_sig     = direccion;
        pend_sig    = pend_nxt;
        cargar      = 1'b0;
        valor_carga = CARGA_PISO;

        if (congelado) begin
            // Frozen: calls still latch, but a call at an open door is absorbed.
            if (estado == PUERTAS) pend_sig[piso] = 1'b0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (pend_nxt[piso]) begin
                        estado_sig     = PUERTAS;
                        pend_sig[piso] = 1'b0;
                        dir_sig        = DIR_PARADO;
                        cargar         = 1'b1;
                        valor_carga    = CARGA_PUERTA;
                    end else if (hay_arriba) begin
                        estado_sig = MOVIENDO;
                        dir_sig    = DIR_SUBE;
                        cargar     = 1'b1;
                    end else if (hay_abajo) begin
                        estado_sig = MOVIENDO;
                        dir_sig    = DIR_BAJA;
                        cargar     = 1'b1;
                    end
                end

                MOVIENDO: begin
                    if (expira) begin
                        piso_sig = piso_adelante;
                        cargar   = 1'b1;
                        if (pend_nxt[piso_adelante]) begin
                            estado_sig              = PUERTAS;
                            pend_sig[piso_adelante] = 1'b0;
                            valor_carga             = CARGA_PUERTA;
                        end
                    end
                end

                PUERTAS: begin
                    pend_sig[piso] = 1'b0;
                    if (llamadas[piso]) begin
                        // Re-pressing the current floor extends the dwell.
                        cargar      = 1'b1;
                        valor_carga = CARGA_PUERTA;
                    end else if (expira) begin
                        // Keep the current sweep direction if anything lies ahead,
                        // otherwise reverse; idle entry behaves like "up".
                        if ((direccion != DIR_BAJA) && hay_arriba) begin
                            estado_sig = MOVIENDO;
                            dir_sig    = DIR_SUBE;
                            cargar     = 1'b1;
                        end else if (hay_abajo) begin
                            estado_sig = MOVIENDO;
                            dir_sig    = DIR_BAJA;
                            cargar     = 1'b1;
                        end else if (hay_arriba) begin
                            estado_sig = MOVIENDO;
                            dir_sig    = DIR_SUBE;
                            cargar     = 1'b1;
                        end else begin
                            estado_sig = REPOSO;
                            dir_sig    = DIR_PARADO;
                        end
                    end
                end

                default: begin
                    estado_sig = REPOSO;
                    dir_sig    = DIR_PARADO;
                end
            endcase
        end
    end

    // State and output registers; reset puts the car idle at floor 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado           <= REPOSO;
            piso             <= '0;
            direccion        <= DIR_PARADO;
            pendientes       <= '0;
            puertas_abiertas <= 1'b0;
            ocupado          <= 1'b0;
        end else begin
            estado           <= estado_sig;
            piso             <= piso_sig;
            direccion        <= dir_sig;
            pendientes       <= pend_sig;
            puertas_abiertas <= (estado_sig == PUERTAS);
            ocupado          <= (estado_sig != REPOSO);
        end
    end

    temporizador_asc #(
        .ANCHO(TW)
    ) u_temporizador (
        .clk        (clk),
        .rst        (rst),
        .cargar     (cargar),
        .valor_carga(valor_carga),
        .habilitar  (habilitar),
        .expira     (expira)
    );

    // A travel leg must always end inside the building: a call lies ahead.
    always_ff @(posedge clk) begin
        if (!rst && (estado == MOVIENDO) && expira) begin
            assert (((direccion == DIR_SUBE) && (int'(piso) < N_PISOS - 1)) ||
                    ((direccion == DIR_BAJA) && (piso != '0)));
        end
    end

endmodule

// File: tb/tb_controlador_ascensor.sv
// Bench for the elevator car sequencer with a cycle-level behavioural reference model.
// One reference step per clock edge; outputs compared 1 time unit after each edge.
// Directed scenarios first, then randomized calls with occasional asynchronous resets.
module tb_controlador_ascensor;

    localparam int NP    = 4;
    localparam int TPISO = 4;
    localparam int TPUER = 3;

    logic          clk;
    logic          rst;
    logic [NP-1:0] llamadas;
    logic          parada;
    logic [1:0]    piso;
    logic [1:0]    direccion;
    logic          puertas_abiertas;
    logic [NP-1:0] pendientes;
    logic          ocupado;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: integer floor, signed direction, cycles left to next event.
    int      m_piso, m_dir, m_resto;
    bit      m_puertas, m_mov;
    bit [NP-1:0] m_pend;

    controlador_ascensor #(
        .N_PISOS      (NP),
        .TIEMPO_PISO  (TPISO),
        .TIEMPO_PUERTA(TPUER)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .llamadas        (llamadas),
`ifdef ASC_PARADA_EMERGENCIA_EN
        .parada          (parada),
`endif
        .piso            (piso),
        .direccion       (direccion),
        .puertas_abiertas(puertas_abiertas),
        .pendientes      (pendientes),
        .ocupado         (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] dir_cod(input int d);
        if (d > 0) return 2'b01;
        if (d < 0) return 2'b10;
        return 2'b00;
    endfunction

    task automatic modelo_reset();
        m_piso = 0; m_dir = 0; m_resto = 0;
        m_puertas = 0; m_mov = 0; m_pend = '0;
    endtask

    // Pick the next sweep from the pending set: keep heading the same way if
    // calls lie ahead, otherwise turn round, otherwise go idle.
    task automatic elegir(input bit [NP-1:0] p);
        bit arr, aba;
        arr = 0; aba = 0;
        for (int i = 0; i < NP; i++) begin
            if (p[i] && i > m_piso) arr = 1;
            if (p[i] && i < m_piso) aba = 1;
        end
        if (m_dir >= 0 && arr)      m_dir = 1;
        else if (aba)               m_dir = -1;
        else if (arr)               m_dir = 1;
        else                        m_dir = 0;
        m_mov   = (m_dir != 0);
        m_resto = TPISO;
    endtask

    task automatic modelo_paso(input bit [NP-1:0] l, input bit par);
        bit [NP-1:0] p;
        p = m_pend | l;
        if (par) begin
            if (m_puertas) p[m_piso] = 0;
        end else if (m_puertas) begin
            p[m_piso] = 0;
            if (l[m_piso]) m_resto = TPUER;
            else begin
                m_resto--;
                if (m_resto == 0) begin
                    m_puertas = 0;
                    elegir(p);
                end
            end
        end else if (m_mov) begin
            m_resto--;
            if (m_resto == 0) begin
                m_piso += m_dir;
                if (p[m_piso]) begin
                    p[m_piso] = 0;
                    m_mov = 0; m_puertas = 1; m_resto = TPUER;
                end else begin
                    m_resto = TPISO;
                end
            end
        end else begin
            if (p[m_piso]) begin
                p[m_piso] = 0;
                m_puertas = 1; m_resto = TPUER; m_dir = 0;
            end else begin
                elegir(p);
            end
        end
        m_pend = p;
    endtask

    task automatic comparar(input string tag);
        chk({tag, ".piso"},       32'(piso),             32'(m_piso));
        chk({tag, ".direccion"},  32'(direccion),        32'(dir_cod(m_dir)));
        chk({tag, ".puertas"},    32'(puertas_abiertas), 32'(m_puertas));
        chk({tag, ".pendientes"}, 32'(pendientes),       32'(m_pend));
        chk({tag, ".ocupado"},    32'(ocupado),          32'(m_puertas | m_mov));
    endtask

    // One clock: drive at the falling edge, step the model at the rising edge, compare after.
    task automatic ciclo(input logic [NP-1:0] l, input bit par, input string tag);
        @(negedge clk);
        llamadas = l;
        parada   = par;
        @(posedge clk);
        modelo_paso(l, par);
        #1;
        comparar(tag);
    endtask

    task automatic esperar(input int n, input string tag);
        for (int k = 0; k < n; k++) ciclo('0, 1'b0, tag);
    endtask

    // Asynchronous reset between edges: outputs must clear without a clock.
    task automatic reset_asinc(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        modelo_reset();
        comparar(tag);
        chk({tag, ".pend_perdidas"}, 32'(pendientes), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        llamadas = '0;
        parada   = 1'b0;
        modelo_reset();
        #1;
        comparar("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Call at the current floor: doors open at once for the dwell time.
        ciclo(4'b0001, 1'b0, "s1");
        chk("s1.abre_inmediato", 32'(puertas_abiertas), 32'd1);
        esperar(5, "s1");

        // Trip to the top floor, then a call at 0 while the doors are open.
        ciclo(4'b1000, 1'b0, "s2");
        esperar(12, "s2");
        chk("s2.llega_piso3", 32'(piso), 32'd3);
        chk("s2.abre_piso3",  32'(puertas_abiertas), 32'd1);
        ciclo(4'b0001, 1'b0, "s4");
        esperar(14, "s4");
        chk("s4.llega_piso0", 32'(piso), 32'd0);
        chk("s4.dir_baja",    32'(direccion), 32'd2);
        esperar(5, "s4");

        // Intermediate call picked up en route.
        ciclo(4'b1000, 1'b0, "s3");
        ciclo(4'b0000, 1'b0, "s3");
        ciclo(4'b0100, 1'b0, "s3");
        esperar(6, "s3");
        chk("s3.para_piso2", 32'(piso), 32'd2);
        chk("s3.abre_piso2", 32'(puertas_abiertas), 32'd1);
        esperar(14, "s3");

        // Re-pressing the current floor extends the dwell.
        ciclo(4'b1000, 1'b0, "s5");
        ciclo(4'b0000, 1'b0, "s5");
        ciclo(4'b1000, 1'b0, "s5");
        esperar(2, "s5");
        chk("s5.sigue_abierta", 32'(puertas_abiertas), 32'd1);
        esperar(1, "s5");
        chk("s5.cierra", 32'(puertas_abiertas), 32'd0);

        // Reset mid-travel between floors.
        ciclo(4'b0001, 1'b0, "s6");
        esperar(9, "s6");
        reset_asinc("s6.rst");

        // Randomized calls, optional emergency stop, rare resets.
        for (int c = 0; c < 1500; c++) begin
            logic [NP-1:0] l;
            bit par;
            l = ($urandom_range(0, 5) == 0) ? NP'($urandom) : '0;
            par = 1'b0;
`ifdef ASC_PARADA_EMERGENCIA_EN
            par = ($urandom_range(0, 9) == 0);
`endif
            if ($urandom_range(0, 399) == 0) reset_asinc("rnd.rst");
            else ciclo(l, par, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
